// File: rtl/sdhci_obi_reg_adapter.sv
// sdhci_obi_reg_adapter: OBI subordinate front-end for the SDHCI register file.
// Turns each OBI A-channel request into one valid/ready register-bus access and
// returns the result on the R-channel, with only one transaction in flight at a time.
// Illegal addresses are answered locally with an error and never reach the register bus.
// Optional feature: define SDHCI_OBI_TIMEOUT_EN to force an error response when the
// register bus does not answer within TimeoutCycles cycles of WAIT.

package sdhci_obi_reg_adapter_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [3:0]  aid;
  } obi_a_t;

  typedef struct packed {
    logic   req;
    obi_a_t a;
  } obi_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [3:0]  rid;
  } obi_r_t;

  typedef struct packed {
    logic   gnt;
    logic   rvalid;
    obi_r_t r;
  } obi_rsp_t;
endpackage

module sdhci_obi_reg_adapter #(
  parameter type         obi_req_t     = sdhci_obi_reg_adapter_pkg::obi_req_t,
  parameter type         obi_rsp_t     = sdhci_obi_reg_adapter_pkg::obi_rsp_t,
  parameter int unsigned RegSpaceBytes = 256,
  parameter int unsigned TimeoutCycles = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  obi_req_t    obi_req_i,
  output obi_rsp_t    obi_rsp_o,
  output logic        reg_valid_o,
  input  logic        reg_ready_i,
  output logic [7:0]  reg_addr_o,
  output logic        reg_we_o,
  output logic [3:0]  reg_be_o,
  output logic [31:0] reg_wdata_o,
  input  logic        reg_rsp_valid_i,
  input  logic [31:0] reg_rdata_i,
  input  logic        reg_err_i
);

  localparam int AddrW = $bits(obi_req_i.a.addr);
  localparam int AidW  = $bits(obi_req_i.a.aid);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [AidW-1:0]   rid_q, rid_d;
  logic              we_q, we_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              bad_addr;
  logic              accept;

`ifdef SDHCI_OBI_TIMEOUT_EN
  localparam int CntW = $clog2(TimeoutCycles + 1);
  // Expiry is detected on the edge that would bring the count to TimeoutCycles,
  // so WAIT lasts exactly TimeoutCycles cycles.
  localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);
  logic [CntW-1:0]   cnt_q, cnt_d;
`endif

  // Out-of-range or misaligned addresses are answered locally.
  assign bad_addr = (obi_req_i.a.addr >= AddrW'(RegSpaceBytes)) |
                    (obi_req_i.a.addr[1:0] != 2'b00);

  // Next-state, capture values and all outputs.
  always_comb begin
    state_d     = state_q;
    rid_d       = rid_q;
    we_d        = we_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
`ifdef SDHCI_OBI_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    accept      = 1'b0;
    reg_valid_o = 1'b0;
    reg_addr_o  = '0;
    reg_we_o    = 1'b0;
    reg_be_o    = '0;
    reg_wdata_o = '0;
    obi_rsp_o   = '0;

    unique case (state_q)
      IDLE: begin
        reg_valid_o   = obi_req_i.req & ~bad_addr;
        accept        = obi_req_i.req & (bad_addr | reg_ready_i);
        obi_rsp_o.gnt = accept;
        if (reg_valid_o) begin
          reg_addr_o  = obi_req_i.a.addr[7:0];
          reg_we_o    = obi_req_i.a.we;
          reg_be_o    = obi_req_i.a.be;
          reg_wdata_o = obi_req_i.a.wdata;
        end
        if (accept) begin
          rid_d = obi_req_i.a.aid;
          we_d  = obi_req_i.a.we;
          if (bad_addr) begin
            state_d = RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = WAIT;
`ifdef SDHCI_OBI_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end

      WAIT: begin
`ifdef SDHCI_OBI_TIMEOUT_EN
        cnt_d = cnt_q + CntW'(1);
`endif
        // A real response takes priority over a timeout on the same edge.
        if (reg_rsp_valid_i) begin
          state_d = RESP;
          rdata_d = we_q ? 32'h0 : reg_rdata_i;
          err_d   = reg_err_i;
`ifdef SDHCI_OBI_TIMEOUT_EN
        end else if (cnt_q == CntLast) begin
          state_d = RESP;
          rdata_d = '0;
          err_d   = 1'b1;
`endif
        end
      end

      RESP: begin
        obi_rsp_o.rvalid  = 1'b1;
        obi_rsp_o.r.rdata = rdata_q;
        obi_rsp_o.r.err   = err_q;
        obi_rsp_o.r.rid   = rid_q;
        state_d           = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and capture registers; reset drops any pending response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      rid_q   <= '0;
      we_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef SDHCI_OBI_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      rid_q   <= rid_d;
      we_q    <= we_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
`ifdef SDHCI_OBI_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

endmodule

// File: tb/tb_sdhci_obi_reg_adapter.sv
// Self-checking bench for sdhci_obi_reg_adapter: expected R-channel beats are queued
// when a request is granted and compared when rvalid appears.
module tb_sdhci_obi_reg_adapter;
  import sdhci_obi_reg_adapter_pkg::*;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  obi_req_t    req;
  obi_rsp_t    rsp;
  logic        reg_valid;
  logic        reg_ready;
  logic [7:0]  reg_addr;
  logic        reg_we;
  logic [3:0]  reg_be;
  logic [31:0] reg_wdata;
  logic        rsp_valid;
  logic [31:0] rdata_in;
  logic        err_in;

  obi_r_t      sb[$];
  int          n_vec = 0;
  int          n_err = 0;

  sdhci_obi_reg_adapter #(
    .RegSpaceBytes(256),
    .TimeoutCycles(TO)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .obi_req_i      (req),
    .obi_rsp_o      (rsp),
    .reg_valid_o    (reg_valid),
    .reg_ready_i    (reg_ready),
    .reg_addr_o     (reg_addr),
    .reg_we_o       (reg_we),
    .reg_be_o       (reg_be),
    .reg_wdata_o    (reg_wdata),
    .reg_rsp_valid_i(rsp_valid),
    .reg_rdata_i    (rdata_in),
    .reg_err_i      (err_in)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every rvalid must match the oldest queued expectation.
  always @(negedge clk) begin
    obi_r_t e;
    if (rst_n && rsp.rvalid) begin
      if (sb.size() == 0) begin
        check_val("rvalid_unexpected", 64'(1), 64'(0));
      end else begin
        e = sb.pop_front();
        check_val("r_rdata", 64'(rsp.r.rdata), 64'(e.rdata));
        check_val("r_err",   64'(rsp.r.err),   64'(e.err));
        check_val("r_rid",   64'(rsp.r.rid),   64'(e.rid));
      end
    end
  end

  // One complete transaction; bad addresses are expected to bypass the register bus.
  task automatic xfer(input logic [31:0] addr, input logic we, input logic [3:0] be,
                      input logic [31:0] wdata, input logic [3:0] aid,
                      input int ready_lat, input int rsp_lat,
                      input logic [31:0] rd, input logic er);
    logic   bad;
    obi_r_t e;
    bad = (addr >= 32'd256) || (addr[1:0] != 2'b00);
    @(posedge clk); #1;
    req.req     = 1'b1;
    req.a.addr  = addr;
    req.a.we    = we;
    req.a.be    = be;
    req.a.wdata = wdata;
    req.a.aid   = aid;
    reg_ready   = 1'b0;
    for (int c = 0; c <= ready_lat; c++) begin
      if (c == ready_lat) reg_ready = 1'b1;
      @(negedge clk);
      check_val("reg_valid", 64'(reg_valid), 64'(!bad));
      check_val("gnt", 64'(rsp.gnt), 64'(bad || (c == ready_lat)));
      if (!bad && c == ready_lat) begin
        check_val("reg_addr",  64'(reg_addr),  64'(addr[7:0]));
        check_val("reg_we",    64'(reg_we),    64'(we));
        check_val("reg_be",    64'(reg_be),    64'(be));
        check_val("reg_wdata", 64'(reg_wdata), 64'(wdata));
      end
      if (c < ready_lat) begin
        @(posedge clk); #1;
      end
    end
    e.rdata = (bad || we) ? 32'h0 : rd;
    e.err   = bad ? 1'b1 : er;
    e.rid   = aid;
    sb.push_back(e);
    @(posedge clk); #1;
    req       = '0;
    reg_ready = 1'b0;
    if (!bad) begin
      for (int c = 1; c < rsp_lat; c++) begin
        @(negedge clk);
        check_val("wait_no_rvalid", 64'(rsp.rvalid), 64'(0));
        @(posedge clk); #1;
      end
      rsp_valid = 1'b1;
      rdata_in  = rd;
      err_in    = er;
      @(negedge clk);
      check_val("wait_no_rvalid", 64'(rsp.rvalid), 64'(0));
      check_val("wait_no_valid", 64'(reg_valid), 64'(0));
      @(posedge clk); #1;
      rsp_valid = 1'b0;
      rdata_in  = '0;
      err_in    = 1'b0;
    end
    @(negedge clk);
    check_val("rvalid_lat", 64'(rsp.rvalid), 64'(1));
    check_val("resp_gnt", 64'(rsp.gnt), 64'(0));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    obi_r_t e;
    int     seen;
    rst_n     = 1'b0;
    req       = '0;
    reg_ready = 1'b0;
    rsp_valid = 1'b0;
    rdata_in  = '0;
    err_in    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("reset_rsp", 64'(rsp), 64'(0));
    check_val("reset_reg_valid", 64'(reg_valid), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Plain read, then a write stalled by the register bus.
    xfer(32'h030, 1'b0, 4'hF, 32'h0, 4'd1, 0, 1, 32'h0001_8000, 1'b0);
    xfer(32'h02C, 1'b1, 4'b0010, 32'h0000_0400, 4'd2, 3, 1, 32'hFFFF_FFFF, 1'b0);
    // Illegal addresses: out of range and misaligned.
    xfer(32'h100, 1'b0, 4'hF, 32'h0, 4'd3, 0, 1, 32'h0, 1'b0);
    xfer(32'h022, 1'b0, 4'hF, 32'h0, 4'd4, 0, 1, 32'h0, 1'b0);
    // Last legal word, slow response carrying a bus error.
    xfer(32'h0FC, 1'b0, 4'hF, 32'h0, 4'd6, 1, 3, 32'hCAFE_F00D, 1'b1);

    // A response strobe while idle must be ignored.
    @(posedge clk); #1;
    rsp_valid = 1'b1;
    rdata_in  = 32'h1234_5678;
    @(posedge clk); #1;
    rsp_valid = 1'b0;
    @(negedge clk);
    check_val("idle_rsp_ignored", 64'(rsp.rvalid), 64'(0));

    // Register bus never answers.
    @(posedge clk); #1;
    req.req    = 1'b1;
    req.a.addr = 32'h040;
    req.a.we   = 1'b0;
    req.a.be   = 4'hF;
    req.a.aid  = 4'd9;
    reg_ready  = 1'b1;
    @(negedge clk);
    check_val("to_gnt", 64'(rsp.gnt), 64'(1));
`ifdef SDHCI_OBI_TIMEOUT_EN
    e.rdata = 32'h0; e.err = 1'b1; e.rid = 4'd9;
    sb.push_back(e);
    @(posedge clk); #1;
    req = '0; reg_ready = 1'b0;
    for (int k = 0; k < TO; k++) begin
      @(negedge clk);
      check_val("to_early_rvalid", 64'(rsp.rvalid), 64'(0));
      @(posedge clk); #1;
    end
    @(negedge clk);
    check_val("to_rvalid", 64'(rsp.rvalid), 64'(1));
`else
    @(posedge clk); #1;
    req = '0; reg_ready = 1'b0;
    seen = 0;
    repeat (100) begin
      @(negedge clk);
      if (rsp.rvalid) seen++;
    end
    check_val("no_to_rvalid", 64'(seen), 64'(0));
    e.rdata = 32'h55; e.err = 1'b0; e.rid = 4'd9;
    sb.push_back(e);
    @(posedge clk); #1;
    rsp_valid = 1'b1; rdata_in = 32'h55;
    @(posedge clk); #1;
    rsp_valid = 1'b0; rdata_in = '0;
    @(negedge clk);
    check_val("late_rvalid", 64'(rsp.rvalid), 64'(1));
`endif

    // Back-to-back reads with req held high.
    @(posedge clk); #1;
    req.req    = 1'b1;
    req.a.addr = 32'h010;
    req.a.we   = 1'b0;
    req.a.be   = 4'hF;
    req.a.aid  = 4'd3;
    reg_ready  = 1'b1;
    @(negedge clk);
    check_val("b2b_gnt0", 64'(rsp.gnt), 64'(1));
    e.rdata = 32'h1111; e.err = 1'b0; e.rid = 4'd3;
    sb.push_back(e);
    @(posedge clk); #1;
    req.a.addr = 32'h014;
    req.a.aid  = 4'd5;
    rsp_valid  = 1'b1;
    rdata_in   = 32'h1111;
    @(negedge clk);
    check_val("b2b_wait_gnt", 64'(rsp.gnt), 64'(0));
    check_val("b2b_wait_valid", 64'(reg_valid), 64'(0));
    @(posedge clk); #1;
    rsp_valid = 1'b0;
    @(negedge clk);
    check_val("b2b_resp_gnt", 64'(rsp.gnt), 64'(0));
    check_val("b2b_resp_rvalid", 64'(rsp.rvalid), 64'(1));
    @(posedge clk); #1;
    @(negedge clk);
    check_val("b2b_gnt1", 64'(rsp.gnt), 64'(1));
    check_val("b2b_addr1", 64'(reg_addr), 64'(8'h14));
    e.rdata = 32'h2222; e.err = 1'b0; e.rid = 4'd5;
    sb.push_back(e);
    @(posedge clk); #1;
    req = '0; reg_ready = 1'b0;
    rsp_valid = 1'b1; rdata_in = 32'h2222;
    @(posedge clk); #1;
    rsp_valid = 1'b0; rdata_in = '0;
    @(negedge clk);
    check_val("b2b_rvalid1", 64'(rsp.rvalid), 64'(1));

    // Reset during WAIT drops the transaction; a late response is ignored.
    @(posedge clk); #1;
    req.req    = 1'b1;
    req.a.addr = 32'h030;
    req.a.we   = 1'b0;
    req.a.be   = 4'hF;
    req.a.aid  = 4'd7;
    reg_ready  = 1'b1;
    @(negedge clk);
    check_val("rst_gnt", 64'(rsp.gnt), 64'(1));
    @(posedge clk); #1;
    req = '0; reg_ready = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check_val("rst_mid_rsp", 64'(rsp), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    rsp_valid = 1'b1; rdata_in = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    rsp_valid = 1'b0; rdata_in = '0;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (rsp != '0) seen++;
    end
    check_val("rst_late_rsp", 64'(seen), 64'(0));
    xfer(32'h008, 1'b0, 4'hF, 32'h0, 4'd8, 0, 2, 32'hA5A5_0001, 1'b0);

    repeat (2) @(negedge clk);
    check_val("sb_empty", 64'(sb.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
